// File: rtl/memory_access.sv
// Memory-access pipeline stage: registers execute results, runs ld/str over a req/ack port, emits one writeback packet.
// Optional access timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module memory_access #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        rd_num_in,
  input  logic [31:0]       rd_val_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [31:0]       cpsr_in,
  input  logic              is_alu_op_in,
  input  logic              is_cmp_op_in,
  input  logic              is_ld_op_in,
  input  logic              is_str_op_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_we,
  output logic [3:0]        wb_rd_num,
  output logic [31:0]       wb_data,
  output logic              wb_cpsr_we,
  output logic [31:0]       wb_cpsr,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RETIRE} state_t;

  state_t     state;
  logic [3:0] rd_num_q;
  logic       is_ld_q;
  logic       mem_op;
  logic       str_only;

  assign in_ready = (state == IDLE);
  assign mem_op   = is_ld_op_in | is_str_op_in;
  // A request flagged as both ld and str is treated as a load.
  assign str_only = is_str_op_in & ~is_ld_op_in;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_num_q   <= '0;
      is_ld_q    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_reg_we  <= 1'b0;
      wb_rd_num  <= '0;
      wb_data    <= '0;
      wb_cpsr_we <= 1'b0;
      wb_cpsr    <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wait_cnt   <= '0;
      mem_err    <= 1'b0;
`endif
    end else begin
      wb_valid   <= 1'b0;
      wb_reg_we  <= 1'b0;
      wb_cpsr_we <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      mem_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mem_op) begin
              state      <= ACCESS;
              rd_num_q   <= rd_num_in;
              is_ld_q    <= is_ld_op_in;
              dmem_req   <= 1'b1;
              dmem_we    <= str_only;
              dmem_addr  <= mem_addr_in[ADDR_W-1:0];
              dmem_wdata <= str_only ? rd_val_in : 32'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end else begin
              wb_valid   <= 1'b1;
              wb_reg_we  <= is_alu_op_in;
              wb_rd_num  <= rd_num_in;
              wb_data    <= alu_result_in;
              wb_cpsr_we <= is_cmp_op_in;
              wb_cpsr    <= cpsr_in;
            end
          end
        end

        // The writeback pulse is launched on the ack edge so it lands in the RETIRE cycle.
        ACCESS: begin
          if (dmem_ack) begin
            state     <= RETIRE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            wb_valid  <= 1'b1;
            wb_reg_we <= is_ld_q;
            wb_rd_num <= rd_num_q;
            if (is_ld_q) begin
              wb_data <= dmem_rdata;
            end
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (timeout_hit) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RETIRE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus queues expected writeback packets, a monitor pops and compares them.
module tb_memory_access;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  rd_num_in;
  logic [31:0] rd_val_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_addr_in;
  logic [31:0] cpsr_in;
  logic        is_alu_op_in;
  logic        is_cmp_op_in;
  logic        is_ld_op_in;
  logic        is_str_op_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_we;
  logic [3:0]  wb_rd_num;
  logic [31:0] wb_data;
  logic        wb_cpsr_we;
  logic [31:0] wb_cpsr;
  logic        mem_err;

  typedef struct {
    logic        reg_we;
    logic [3:0]  rd;
    logic [31:0] data;
    logic        cpsr_we;
    logic [31:0] cpsr;
    logic        err;
    int          due;
  } exp_pkt_t;

  exp_pkt_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  memory_access #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_num_in(rd_num_in), .rd_val_in(rd_val_in),
    .alu_result_in(alu_result_in), .mem_addr_in(mem_addr_in), .cpsr_in(cpsr_in),
    .is_alu_op_in(is_alu_op_in), .is_cmp_op_in(is_cmp_op_in),
    .is_ld_op_in(is_ld_op_in), .is_str_op_in(is_str_op_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_rd_num(wb_rd_num),
    .wb_data(wb_data), .wb_cpsr_we(wb_cpsr_we), .wb_cpsr(wb_cpsr),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void push_exp(input logic reg_we, input logic [3:0] rd, input logic [31:0] data,
                                   input logic cpsr_we, input logic [31:0] cpsr, input logic err, input int due);
    exp_pkt_t p;
    p.reg_we = reg_we; p.rd = rd; p.data = data;
    p.cpsr_we = cpsr_we; p.cpsr = cpsr; p.err = err; p.due = due;
    exp_q.push_back(p);
  endfunction

  // Monitor: every writeback (or error) pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_pkt_t e;
    if (wb_valid === 1'b1 || mem_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL wb_unexpected: got wb_valid=%0b mem_err=%0b, expected no pulse (cycle %0d)",
                 wb_valid, mem_err, cyc);
      end else begin
        e = exp_q.pop_front();
        check_output("wb_cycle", cyc, e.due);
        check_output("wb_valid", {31'd0, wb_valid}, 32'd1);
        check_output("wb_reg_we", {31'd0, wb_reg_we}, {31'd0, e.reg_we});
        check_output("wb_cpsr_we", {31'd0, wb_cpsr_we}, {31'd0, e.cpsr_we});
        check_output("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        if (e.reg_we) begin
          check_output("wb_rd_num", {28'd0, wb_rd_num}, {28'd0, e.rd});
          check_output("wb_data", wb_data, e.data);
        end
        if (e.cpsr_we) begin
          check_output("wb_cpsr", wb_cpsr, e.cpsr);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic alu, input logic cmp, input logic ld, input logic str,
                                input logic [3:0] rd, input logic [31:0] rd_val, input logic [31:0] alu_res,
                                input logic [31:0] addr, input logic [31:0] cpsr);
    in_valid = 1'b1;
    is_alu_op_in = alu; is_cmp_op_in = cmp; is_ld_op_in = ld; is_str_op_in = str;
    rd_num_in = rd; rd_val_in = rd_val; alu_result_in = alu_res;
    mem_addr_in = addr; cpsr_in = cpsr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    is_alu_op_in = 1'b0; is_cmp_op_in = 1'b0; is_ld_op_in = 1'b0; is_str_op_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check_output("drain", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_ack(input logic [31:0] rdata);
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    is_alu_op_in = 1'b0; is_cmp_op_in = 1'b0; is_ld_op_in = 1'b0; is_str_op_in = 1'b0;
    rd_num_in = '0; rd_val_in = '0; alu_result_in = '0; mem_addr_in = '0; cpsr_in = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check_output("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_output("rst_mem_err", {31'd0, mem_err}, 32'd0);
    check_output("rst_dmem_addr", dmem_addr, 32'd0);
    check_output("rst_wb_data", wb_data, 32'd0);
    @(posedge clk);
    #1;

    // ALU then cmp, back to back
    push_exp(1'b1, 4'd3, 32'h0000_1234, 1'b0, 32'd0, 1'b0, cyc + 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 32'd0, 32'h0000_1234, 32'd0, 32'd0);
    push_exp(1'b0, 4'd0, 32'd0, 1'b1, 32'h0000_0006, 1'b0, cyc + 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'h0000_0006);
    wait_drain();

    // Load acked on the 3rd ACCESS cycle; an ALU op offered meanwhile must be ignored
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'd0, 32'd0, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("ld_req", {31'd0, dmem_req}, 32'd1);
      check_output("ld_addr", dmem_addr, 32'h0000_0040);
      check_output("ld_we", {31'd0, dmem_we}, 32'd0);
      check_output("ld_in_ready", {31'd0, in_ready}, 32'd0);
      if (i == 0) begin
        in_valid = 1'b1; is_alu_op_in = 1'b1; rd_num_in = 4'd1; alu_result_in = 32'h0000_0BAD;
      end
      if (i == 2) begin
        in_valid = 1'b0; is_alu_op_in = 1'b0;
        push_exp(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, cyc + 1);
        pulse_ack(32'hDEAD_BEEF);
      end
    end
    @(negedge clk);
    check_output("ld_req_drop", {31'd0, dmem_req}, 32'd0);
    check_output("ld_retire_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_output("ld_in_ready_back", {31'd0, in_ready}, 32'd1);
    wait_drain();

    // Store with same-cycle ack
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'hA5A5_A5A5, 32'd0, 32'h003F_FFFC, 32'd0);
    @(negedge clk);
    check_output("st_req", {31'd0, dmem_req}, 32'd1);
    check_output("st_we", {31'd0, dmem_we}, 32'd1);
    check_output("st_addr", dmem_addr, 32'h003F_FFFC);
    check_output("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
    push_exp(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, cyc + 1);
    pulse_ack(32'h1234_5678);
    @(negedge clk);
    check_output("st_req_drop", {31'd0, dmem_req}, 32'd0);
    check_output("st_retire_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_output("st_in_ready_back", {31'd0, in_ready}, 32'd1);
    wait_drain();

    // ld+str+cmp together: treated as a plain load, cmp dropped
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 32'h0000_1111, 32'd0, 32'h0000_0080, 32'h0000_000F);
    @(negedge clk);
    check_output("both_we", {31'd0, dmem_we}, 32'd0);
    check_output("both_wdata", dmem_wdata, 32'd0);
    check_output("both_addr", dmem_addr, 32'h0000_0080);
    push_exp(1'b1, 4'd9, 32'h5555_AAAA, 1'b0, 32'd0, 1'b0, cyc + 1);
    pulse_ack(32'h5555_AAAA);
    wait_drain();

    // Stray ack while idle
    @(posedge clk);
    #1;
    pulse_ack(32'hFFFF_FFFF);
    @(negedge clk);
    check_output("idle_ack_req", {31'd0, dmem_req}, 32'd0);
    check_output("idle_ack_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during the 2nd ACCESS cycle discards the load
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'd0, 32'd0, 32'h0000_0100, 32'd0);
    @(negedge clk);
    check_output("rma_req_before", {31'd0, dmem_req}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rma_req_after", {31'd0, dmem_req}, 32'd0);
    check_output("rma_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_output("rma_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    pulse_ack(32'h0BAD_0BAD);
    @(negedge clk);
    check_output("rma_late_ack_req", {31'd0, dmem_req}, 32'd0);
    check_output("rma_late_ack_wb", {31'd0, wb_valid}, 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Load never acked: times out after 4 request cycles
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 32'd0, 32'd0, 32'h0000_0200, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("to_req", {31'd0, dmem_req}, 32'd1);
      check_output("to_no_err", {31'd0, mem_err}, 32'd0);
      if (i == 3) push_exp(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, cyc + 1);
    end
    @(negedge clk);
    check_output("to_req_drop", {31'd0, dmem_req}, 32'd0);
    check_output("to_in_ready", {31'd0, in_ready}, 32'd1);
    wait_drain();

    // Ack in the same cycle the count expires wins
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 32'd0, 32'd0, 32'h0000_0204, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("to_race_req", {31'd0, dmem_req}, 32'd1);
      if (i == 3) begin
        push_exp(1'b1, 4'd6, 32'h0000_0077, 1'b0, 32'd0, 1'b0, cyc + 1);
        pulse_ack(32'h0000_0077);
      end
    end
    wait_drain();
`else
    // Without the timeout a load waits indefinitely for its ack
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 32'd0, 32'd0, 32'h0000_0200, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("long_req", {31'd0, dmem_req}, 32'd1);
      check_output("long_no_err", {31'd0, mem_err}, 32'd0);
      if (i == 7) begin
        push_exp(1'b1, 4'd7, 32'hCAFE_F00D, 1'b0, 32'd0, 1'b0, cyc + 1);
        pulse_ack(32'hCAFE_F00D);
      end
    end
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("final_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
